// File: rtl/gpio_pkg.sv
// Shared constants and per-bit debounce FSM encoding for the GPIO input conditioner.
package gpio_pkg;

    localparam int GPIO_WIDTH              = 8;
    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } deb_state_e;

endpackage

// File: rtl/debounce_bit.sv
// One GPIO bit: synchronizer chain, stability counter and STABLE/COUNTING FSM
// producing a debounced level plus a one-cycle change pulse.
module debounce_bit
    import gpio_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic change
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;

    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             change_q, change_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= STABLE;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            change_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            change_q <= change_d;
        end
    end

    // A mismatch edge with the counter at LAST commits the new level; with
    // DEBOUNCE_CYCLES == 1 that happens on the very first mismatch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        change_d = 1'b0;
        case (state_q)
            STABLE: begin
                cnt_d = '0;
                if (sync != level_q) begin
                    if (LAST == '0) begin
                        level_d  = sync;
                        change_d = 1'b1;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = COUNTING;
                    end
                end
            end
            COUNTING: begin
                if (sync == level_q) begin
                    cnt_d   = '0;
                    state_d = STABLE;
                end else if (cnt_q == LAST) begin
                    level_d  = sync;
                    change_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = STABLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = STABLE;
            end
        endcase
    end

    assign level  = level_q;
    assign change = change_q;

endmodule

// File: rtl/gpio_in_conditioner.sv
// Synchronizes and debounces raw GPIO pins per bit; outputs are purely registered.
module gpio_in_conditioner
    import gpio_pkg::*;
#(
    parameter int WIDTH           = GPIO_WIDTH,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gpio_raw_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] change_o,
    output logic             any_change_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk   (clk),
            .rst   (rst),
            .raw   (gpio_raw_i[i]),
            .level (gpio_o[i]),
            .change(change_o[i])
        );
    end

    assign any_change_o = |change_o;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Directed bench: default-parameter DUT and a DEBOUNCE_CYCLES=1 DUT checked against a history model.
module tb_gpio_in_conditioner;

    localparam int SA = 2, DA = 4;
    localparam int SB = 2, DB = 1;
    localparam int HLEN = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] raw_a = 8'h00;
    logic [7:0] raw_b = 8'h00;
    logic [7:0] gpio_a, chg_a, gpio_b, chg_b;
    logic       any_a, any_b;

    int checks = 0;
    int errors = 0;

    gpio_in_conditioner #(.WIDTH(8), .SYNC_STAGES(SA), .DEBOUNCE_CYCLES(DA)) dut_a (
        .clk(clk), .rst(rst), .gpio_raw_i(raw_a),
        .gpio_o(gpio_a), .change_o(chg_a), .any_change_o(any_a));

    gpio_in_conditioner #(.WIDTH(8), .SYNC_STAGES(SB), .DEBOUNCE_CYCLES(DB)) dut_b (
        .clk(clk), .rst(rst), .gpio_raw_i(raw_b),
        .gpio_o(gpio_b), .change_o(chg_b), .any_change_o(any_b));

    always #5 clk = ~clk;

    // Model: hist[j] is the raw value captured j+1 edges ago (0 while in reset).
    // An edge uses the synchronized value captured S edges ago; a bit flips when the
    // last D such values all agree and differ from the current output.
    logic [7:0] hist_a[$];
    logic [7:0] hist_b[$];
    logic [7:0] m_gpio_a = 8'h00, m_chg_a = 8'h00, m_gpio_b = 8'h00, m_chg_b = 8'h00;
    bit         model_ok = 1'b0;

    function automatic void model_step(input logic [7:0] h[$], input int s, input int d,
                                       inout logic [7:0] out, output logic [7:0] chg);
        chg = 8'h00;
        for (int b = 0; b < 8; b++) begin
            logic v;
            bit   agree;
            v = h[s-1][b];
            agree = 1'b1;
            for (int k = 0; k < d; k++)
                if (h[s-1+k][b] !== v) agree = 1'b0;
            if (agree && v !== out[b]) begin
                out[b] = v;
                chg[b] = 1'b1;
            end
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            hist_a = {};
            hist_b = {};
            for (int i = 0; i < HLEN; i++) begin
                hist_a.push_front(8'h00);
                hist_b.push_front(8'h00);
            end
            m_gpio_a = 8'h00; m_chg_a = 8'h00;
            m_gpio_b = 8'h00; m_chg_b = 8'h00;
            model_ok = 1'b1;
        end else begin
            model_step(hist_a, SA, DA, m_gpio_a, m_chg_a);
            model_step(hist_b, SB, DB, m_gpio_b, m_chg_b);
            hist_a.push_front(raw_a);
            void'(hist_a.pop_back());
            hist_b.push_front(raw_b);
            void'(hist_b.pop_back());
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            chk("model gpio_a", gpio_a, m_gpio_a);
            chk("model chg_a", chg_a, m_chg_a);
            chk("model any_a", {7'd0, any_a}, {7'd0, |m_chg_a});
            chk("model gpio_b", gpio_b, m_gpio_b);
            chk("model chg_b", chg_b, m_chg_b);
            chk("model any_b", {7'd0, any_b}, {7'd0, |m_chg_b});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   pulses;
        logic old7;

        // Reset state
        tick(); tick();
        chk("reset gpio_a", gpio_a, 8'h00);
        chk("reset chg_a", chg_a, 8'h00);
        chk("reset gpio_b", gpio_b, 8'h00);
        rst = 1'b0;

        // Quiet inputs
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("quiet chg_a", chg_a, 8'h00);
        end
        chk("quiet gpio_a", gpio_a, 8'h00);

        // 00 -> 05: output lands on the 6th edge, one-cycle pulse
        raw_a = 8'h05;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e < 6) chk("lat pre gpio_a", gpio_a, 8'h00);
        end
        chk("lat gpio_a", gpio_a, 8'h05);
        chk("lat chg_a", chg_a, 8'h05);
        chk("lat any_a", {7'd0, any_a}, 8'h01);
        tick();
        chk("lat chg_a clr", chg_a, 8'h00);
        chk("lat gpio_a hold", gpio_a, 8'h05);

        // Bit 0 glitch of 3 cycles is filtered
        raw_a = 8'h04;
        repeat (10) tick();
        chk("pre glitch gpio_a", gpio_a, 8'h04);
        raw_a = 8'h05;
        repeat (3) tick();
        raw_a = 8'h04;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("glitch gpio_a", gpio_a, 8'h04);
            chk("glitch chg_a", chg_a, 8'h00);
        end

        // Reset mid-count aborts; full latency after release
        raw_a = 8'hFF;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("midrst gpio_a", gpio_a, 8'h00);
        chk("midrst chg_a", chg_a, 8'h00);
        rst = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e < 6) chk("rst lat pre gpio_a", gpio_a, 8'h00);
        end
        chk("rst lat gpio_a", gpio_a, 8'hFF);
        chk("rst lat chg_a", chg_a, 8'hFF);

        // Bits 0,1 rise together, bit 1 drops after 2 cycles
        raw_a = 8'h00;
        repeat (10) tick();
        chk("pre pair gpio_a", gpio_a, 8'h00);
        raw_a = 8'h03;
        pulses = 0;
        repeat (2) tick();
        raw_a = 8'h01;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (chg_a != 8'h00) begin
                pulses++;
                chk("pair chg_a", chg_a, 8'h01);
            end
        end
        chk("pair pulses", 8'(pulses), 8'd1);
        chk("pair gpio_a", gpio_a, 8'h01);

        // DEBOUNCE_CYCLES=1: bit 7 toggles every 4 cycles, 3-edge latency
        for (int t = 0; t < 6; t++) begin
            old7 = raw_b[7];
            raw_b[7] = ~raw_b[7];
            for (int e = 1; e <= 4; e++) begin
                tick();
                if (e == 2) chk("d1 pre gpio_b7", {7'd0, gpio_b[7]}, {7'd0, old7});
                if (e == 3) begin
                    chk("d1 gpio_b7", {7'd0, gpio_b[7]}, {7'd0, ~old7});
                    chk("d1 chg_b7", {7'd0, chg_b[7]}, 8'h01);
                end
                if (e == 4) chk("d1 chg_b7 clr", {7'd0, chg_b[7]}, 8'h00);
            end
        end

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_in_conditioner.md
GPIO_IN_CONDITIONER -- requirements
Module: gpio_in_conditioner

Interface
REQ-001 Parameter: WIDTH, default 8, number of GPIO input bits; must match the core's GPIO_i width.
REQ-002 Parameter: SYNC_STAGES, default 2, synchronizer depth; legal range 2..4.
REQ-003 Parameter: DEBOUNCE_CYCLES, default 4, number of consecutive stable synchronized samples required before an output bit changes; legal range 1..65535.
REQ-004 Port: clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: gpio_raw_i  input  WIDTH  asynchronous external pin levels (switches/buttons).
REQ-007 Port: gpio_o  output  WIDTH  debounced level, driving the core's GPIO_i input directly.
REQ-008 Port: change_o  output  WIDTH  per-bit one-cycle pulse, high in the cycle in which the matching gpio_o bit has just changed.
REQ-009 Port: any_change_o  output  1  OR-reduction of change_o.

Function
REQ-010 Each bit SHALL pass gpio_raw_i through a SYNC_STAGES-deep flop chain; the last stage is "sync".
REQ-011 Each bit SHALL hold a debounce counter, width $clog2(DEBOUNCE_CYCLES+1), and a two-state FSM: STABLE (sync == gpio_o) and COUNTING (sync != gpio_o).
REQ-012 STABLE -> COUNTING on an edge where sync != gpio_o; counter increments from 0 to 1 on that edge.
REQ-013 COUNTING: on each edge where sync != gpio_o and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment.
REQ-014 COUNTING: on the edge where sync != gpio_o and counter == DEBOUNCE_CYCLES-1, gpio_o bit SHALL take the sync value, the change_o bit SHALL be 1 for the following cycle only, the counter SHALL clear, and the FSM SHALL return to STABLE.
REQ-015 COUNTING: on any edge where sync == gpio_o (glitch ended), the counter SHALL clear and the FSM SHALL return to STABLE with no output change.
REQ-016 Latency: a raw level held constant updates gpio_o on exactly the (SYNC_STAGES+DEBOUNCE_CYCLES)-th rising edge, counting the first edge that samples the new level (default: 6th edge).
REQ-017 A pulse shorter than DEBOUNCE_CYCLES synchronized cycles SHALL never change gpio_o or assert change_o.
REQ-018 DEBOUNCE_CYCLES == 1: gpio_o follows sync one edge later, with no filtering.
REQ-019 The counter SHALL never wrap; its maximum value is DEBOUNCE_CYCLES-1.
REQ-020 Bits SHALL be fully independent; simultaneous changes on several bits SHALL produce simultaneous change_o pulses.
REQ-021 gpio_o, change_o and any_change_o SHALL be combinationally independent of gpio_raw_i (registered or derived only from registers).

Reset
REQ-022 While rst is sampled high, all synchronizer flops, gpio_o, counters and change_o SHALL be 0, and every FSM SHALL be in STABLE.
REQ-023 Reset asserted mid-count SHALL abort the count; after release, a raw level of 1 needs the full REQ-016 latency to reach gpio_o.
REQ-024 The first rising edge with rst low SHALL be counted as a normal sampling edge.

Structure
REQ-025 A shared package gpio_pkg SHALL hold GPIO_WIDTH = 8, DEFAULT_SYNC_STAGES = 2, DEFAULT_DEBOUNCE_CYCLES = 4 and the FSM state enum (STABLE, COUNTING).
REQ-026 Per-bit logic SHALL live in sub-module debounce_bit (synchronizer, counter, FSM), instantiated WIDTH times via generate; the top level only adds the any_change_o reduction.
REQ-027 The top level SHALL be instantiated in CoreMips, with gpio_o connected to GPIO_i.

Verification
REQ-028 Reset, then gpio_raw_i = 8'h00 for 20 cycles -> gpio_o = 8'h00; change_o stays 0 throughout.
REQ-029 Defaults: gpio_raw_i 8'h00 -> 8'h05, held -> gpio_o = 8'h05 on the 6th edge; change_o = 8'h05 and any_change_o = 1 for exactly one cycle.
REQ-030 Bit 0 glitch of 3 cycles (0 -> 1 -> 0) -> gpio_o[0] stays 0; change_o[0] never asserts.
REQ-031 gpio_raw_i = 8'hFF held, with rst pulsed high for 1 cycle at the 4th edge -> gpio_o = 8'h00 during reset, then 8'hFF exactly 6 edges after release.
REQ-032 DEBOUNCE_CYCLES = 1: bit 7 toggles every 4 cycles -> gpio_o[7] follows with 3-edge latency, with one change_o[7] pulse per toggle.
REQ-033 Bits 0 and 1 rise on the same edge and bit 1 falls 2 cycles later -> only gpio_o[0] changes; change_o = 8'h01 for one cycle.
